// File: rtl/alu_cmd_issuer.sv
// Issues packed ALU commands under valid/ready and checks the in-order results
// against a locally computed expected value held in a small scoreboard.
module alu_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [3:0]       i_req_data1,
  input  logic [3:0]       i_req_data2,
  input  logic [1:0]       i_req_op,
  output logic             o_cmd_valid,
  input  logic             i_cmd_ready,
  output logic [9:0]       o_cmd_data,
  input  logic             i_rsp_valid,
  input  logic [8:0]       i_rsp_result,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [8:0]       o_out_result,
  output logic [8:0]       o_out_expected,
  output logic [1:0]       o_out_op,
  output logic             o_out_mismatch,
  input  logic             i_flush,
  output logic             o_flush_done,
  output logic             o_err_unexpected,
  output logic [CNT_W-1:0] o_cmd_count,
  output logic [CNT_W-1:0] o_mismatch_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, IDLE} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [PW-1:0]    r_tail;
  logic [PW-1:0]    r_rsp_ptr;
  logic [PW-1:0]    r_head;
  logic [PW:0]      r_occ;
  logic [PW:0]      r_issued;
  logic [1:0]       r_op  [DEPTH];
  logic [8:0]       r_exp [DEPTH];
  logic [8:0]       r_res [DEPTH];
  logic [DEPTH-1:0] r_done;
  logic             r_cmd_valid;
  logic [9:0]       r_cmd_data;
  logic             r_err;
  logic [CNT_W-1:0] r_cmd_count;
  logic [CNT_W-1:0] r_mis_count;

  logic       w_acc;
  logic       w_cmd_hs;
  logic       w_rsp_ok;
  logic       w_out_hs;
  logic       w_drain_done;
  logic [8:0] w_exp;

  // Readiness uses registered occupancy only, so a same-cycle free never opens a slot.
  assign o_req_ready  = !i_reset && (r_state == RUN) && (r_occ < FULL) &&
                        (!r_cmd_valid || i_cmd_ready);
  assign w_acc        = i_req_valid && o_req_ready;
  assign w_cmd_hs     = r_cmd_valid && i_cmd_ready;
  assign w_rsp_ok     = i_rsp_valid && (r_issued != '0);
  assign o_out_valid  = r_done[r_head];
  assign w_out_hs     = o_out_valid && i_out_ready;
  assign w_drain_done = (r_occ == '0) && !r_cmd_valid;

  assign o_out_result     = r_res[r_head];
  assign o_out_expected   = r_exp[r_head];
  assign o_out_op         = r_op[r_head];
  assign o_out_mismatch   = o_out_result != o_out_expected;
  assign o_cmd_valid      = r_cmd_valid;
  assign o_cmd_data       = r_cmd_data;
  assign o_err_unexpected = r_err;
  assign o_cmd_count      = r_cmd_count;
  assign o_mismatch_count = r_mis_count;

  always_comb begin
    w_exp = '0;
    case (i_req_op)
      2'd0:    w_exp = {4'b0, {1'b0, i_req_data1} + {1'b0, i_req_data2}};
      2'd1:    w_exp = {5'b0, i_req_data1} - {5'b0, i_req_data2};
      2'd2:    w_exp = {1'b0, {4'b0, i_req_data1} * {4'b0, i_req_data2}};
      default: w_exp = (i_req_data2 == 4'd0) ? 9'h1FF : {5'b0, i_req_data1 / i_req_data2};
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    o_flush_done = 1'b0;
    case (r_state)
      RUN:     if (i_flush) w_next_state = DRAIN;
      DRAIN: begin
        if (w_drain_done) begin
          o_flush_done = !i_reset;
          w_next_state = IDLE;
        end
      end
      IDLE:    if (!i_flush) w_next_state = RUN;
      default: w_next_state = RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= RUN;
    else         r_state <= w_next_state;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cmd_valid <= 1'b0;
      r_cmd_data  <= '0;
    end else if (w_acc) begin
      r_cmd_valid <= 1'b1;
      r_cmd_data  <= {i_req_op, i_req_data2, i_req_data1};
    end else if (w_cmd_hs) begin
      r_cmd_valid <= 1'b0;
      r_cmd_data  <= '0;
    end
  end

  // Allocation, result capture and free never target the same entry in one cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tail    <= '0;
      r_rsp_ptr <= '0;
      r_head    <= '0;
      r_done    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_op[i]  <= '0;
        r_exp[i] <= '0;
        r_res[i] <= '0;
      end
    end else begin
      if (w_acc) begin
        r_op[r_tail]   <= i_req_op;
        r_exp[r_tail]  <= w_exp;
        r_done[r_tail] <= 1'b0;
        r_tail         <= r_tail + 1'b1;
      end
      if (w_rsp_ok) begin
        r_res[r_rsp_ptr]  <= i_rsp_result;
        r_done[r_rsp_ptr] <= 1'b1;
        r_rsp_ptr         <= r_rsp_ptr + 1'b1;
      end
      if (w_out_hs) begin
        r_done[r_head] <= 1'b0;
        r_head         <= r_head + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_occ       <= '0;
      r_issued    <= '0;
      r_err       <= 1'b0;
      r_cmd_count <= '0;
      r_mis_count <= '0;
    end else begin
      if (w_acc && !w_out_hs)      r_occ <= r_occ + 1'b1;
      else if (!w_acc && w_out_hs) r_occ <= r_occ - 1'b1;
      if (w_cmd_hs && !w_rsp_ok)      r_issued <= r_issued + 1'b1;
      else if (!w_cmd_hs && w_rsp_ok) r_issued <= r_issued - 1'b1;
      if (i_rsp_valid && (r_issued == '0)) r_err <= 1'b1;
      if (w_cmd_hs && (r_cmd_count != '1)) r_cmd_count <= r_cmd_count + 1'b1;
      if (w_out_hs && o_out_mismatch && (r_mis_count != '1))
        r_mis_count <= r_mis_count + 1'b1;
    end
  end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Initiator for the ALU pipeline command interface. It packs operand/opcode requests into 10-bit ALU commands and issues them under a valid/ready handshake. It matches the in-order 9-bit results against a locally computed expected value and returns result, expected value and a mismatch flag to the client. It sits between a test or control master and the ALU-FIFO pipeline input and output ports, and provides flush/drain control and error counters.

## Interface
- DEPTH, 4 — maximum outstanding commands (issued or buffered, result not yet consumed); power of two, ≥2.
- CNT_W, 16 — width of the statistics counters.

Ports:
- clk  in  1  — single clock; all logic on posedge.
- reset  in  1  — synchronous, active-high.
- req_valid  in  1  — client request valid.
- req_ready  out  1  — request accepted when valid && ready.
- req_data1  in  4  — operand A.
- req_data2  in  4  — operand B.
- req_op  in  2  — 0 add, 1 sub, 2 mul, 3 div.
- cmd_valid  out  1  — command valid toward the ALU pipeline.
- cmd_ready  in  1  — pipeline accepts command.
- cmd_data  out  10  — {op[1:0], data2[3:0], data1[3:0]}.
- rsp_valid  in  1  — result valid from the pipeline; always accepted, no ready.
- rsp_result  in  9  — ALU result.
- out_valid  out  1  — checked result available.
- out_ready  in  1  — client consumes the checked result.
- out_result  out  9  — received result.
- out_expected  out  9  — locally computed expected result.
- out_op  out  2  — opcode of the matching command.
- out_mismatch  out  1  — out_result != out_expected.
- flush  in  1  — level; stop accepting requests and drain.
- flush_done  out  1  — one-cycle pulse when the drain completes.
- err_unexpected  out  1  — sticky; rsp_valid with no issued command awaiting a result.
- cmd_count  out  CNT_W  — commands accepted by the pipeline; saturating.
- mismatch_count  out  CNT_W  — mismatching results consumed; saturating.

## Operation
- Scoreboard: DEPTH entries {op, expected[8:0], result[8:0], done}. Three pointers:
  - tail: allocate on request.
  - rsp_ptr: oldest issued entry awaiting its result.
  - head: oldest entry, presented at the output.
  - All pointers wrap modulo DEPTH. Occupancy counter spans 0..DEPTH.
- Request acceptance: req_ready = (state==RUN) && occupancy<DEPTH && (!cmd_valid || cmd_ready).
- On accept:
  - Allocate the tail entry and store op and expected.
  - Load the command register; cmd_valid=1 next cycle.
- Command register: holds cmd_data stable while cmd_valid && !cmd_ready. It clears when accepted and no new request is accepted in the same cycle. Back-to-back issue at one command per cycle is supported.
- Issued-not-returned counter: +1 on cmd handshake, −1 on rsp_valid.
- Response handling: rsp_valid with issued count >0 writes rsp_result into entry[rsp_ptr], sets its done bit, and advances rsp_ptr.
  - Otherwise the response is dropped and err_unexpected is set.
  - Simultaneous cmd handshake and rsp: net counter change 0.
- Output: out_valid = entry[head].done. The output fields come from entry[head].
  - On out handshake: free the entry, advance head, decrement occupancy.
  - If out_mismatch, increment mismatch_count.
  - Allocation and free in the same cycle: occupancy unchanged.
- Expected arithmetic, unsigned 4-bit operands, 9-bit result:
  - add: zero-extended 5-bit sum.
  - sub: (A−B) mod 512.
  - mul: zero-extended 8-bit product.
  - div: floor(A/B); B==0 gives 9'h1FF.
- State machine:
  - RUN: requests accepted. If flush=1, go to DRAIN.
  - DRAIN: req_ready=0. When occupancy==0 && !cmd_valid, pulse flush_done and go to IDLE.
  - IDLE: req_ready=0. When flush=0, go to RUN.
- Counters saturate at all-ones. Sticky error clears only on reset.

## Timing
- Reset values:
  - Outputs: req_ready=0 during reset, cmd_valid=0, cmd_data=0, out_valid=0, out_result=0, out_expected=0, out_op=0, out_mismatch=0, flush_done=0, err_unexpected=0, both counters 0.
  - Internal: state RUN, pointers 0, occupancy 0, all done bits 0.
- Reset asserted mid-operation discards all outstanding entries and the command register on the next edge. Late responses after reset set err_unexpected.
- Request accept at edge t → cmd_valid from t+1.
- rsp_valid sampled at edge t for the head entry → out_valid from t+1.
- A freed entry is available for allocation from the cycle after the out handshake; req_ready is computed from registered occupancy.
- With occupancy==DEPTH, req_ready=0 even if out_ready is high in the same cycle.
- flush rising in RUN at edge t: req_ready=0 from t+1. A request accepted at t is still issued and drained.
- flush_done asserts for exactly one cycle.

## Test plan
- Single add 5+7: cmd_data=10'h075 one cycle after accept. Return rsp 9'd12 → out_valid, out_expected=12, out_mismatch=0, cmd_count=1.
- Sub 3−9 and div 9/0 back-to-back with cmd_ready=1. Return 9'h1FA then 9'h1FF → both match, in order, mismatch_count=0.
- DEPTH=4: issue 4 muls 15*15 with rsp and out stalled → req_ready=0 at occupancy 4. One out handshake → req_ready=1 next cycle. out_expected=225 for each.
- cmd_ready held low 5 cycles → cmd_data stable, cmd_valid stays 1, no second request accepted.
- Return rsp 9'd1 for add 2+2 → out_mismatch=1, mismatch_count=1 after consume. rsp_valid with nothing issued → err_unexpected=1, sticky.
- Assert flush with 2 outstanding → req_ready=0, both results returned and consumed, then a flush_done single pulse and IDLE. Deassert flush → RUN.
